// File: rtl/addsub_pipe_pkg.sv
// addsub_pipe_pkg: shared helpers and types for the pipelined add/subtract unit.
//   chunk_width() : width of one pipeline chunk (WIDTH / STAGES)
//   config_ok()   : elaboration-time legality of a WIDTH/STAGES pair
//   stage_ctrl_t  : per-stage control bits that travel with each beat
package addsub_pipe_pkg;

  // Width of the slice handled by each stage; guarded so a bad STAGES
  // value still elaborates far enough to report the configuration error.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // WIDTH must split into STAGES equal, non-empty chunks.
  function automatic bit config_ok(input int unsigned width,
                                   input int unsigned stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Control portion of a stage register: beat valid and the chunk carry-out
  // handed to the next stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CW-bit ripple-carry adder built from one-bit
// dataflow full-adder cells.
//   a, b   : chunk operands (b already inverted for subtraction)
//   cin    : carry into bit 0
//   sum    : chunk result
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (used for signed overflow detection)
module addsub_chunk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);

  logic [CW:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit.
  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract unit. A WIDTH-bit operation is split
// into STAGES chunks of CW bits; stage k adds chunk k using the carry
// registered by stage k-1. Operand chunks are skewed forward until their
// stage and finished result chunks are deskewed until the last stage, so a
// beat emerges whole STAGES cycles after acceptance.
//
// Ports:
//   clk_94, reset_94            : clock, asynchronous active-high reset
//   in_valid_94 / in_ready_94   : operand handshake (in_ready_94 is combinational)
//   a_94, b_94, sub_94, cin_94  : operands, 1 = subtract, carry/borrow in
//   out_valid_94 / out_ready_94 : result handshake
//   sum_94, cout_94             : result, carry-out (inverted borrow on subtract)
//   ovf_94                      : signed overflow, only with ADDPIPE_OVERFLOW_EN
//
// Build option: define ADDPIPE_OVERFLOW_EN to add the ovf_94 port and logic.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk_94,
  input  logic             reset_94,
  input  logic             in_valid_94,
  output logic             in_ready_94,
  input  logic [WIDTH-1:0] a_94,
  input  logic [WIDTH-1:0] b_94,
  input  logic             sub_94,
  input  logic             cin_94,
  output logic             out_valid_94,
  input  logic             out_ready_94,
  output logic [WIDTH-1:0] sum_94,
  output logic             cout_94
`ifdef ADDPIPE_OVERFLOW_EN
  ,
  output logic             ovf_94
`endif
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a nonzero multiple of STAGES");
  end

  // Stage registers: [stage][chunk]. Operand slots are live only for chunks
  // beyond the stage, result slots only for chunks up to the stage.
  stage_ctrl_t   ctrl_q [STAGES];
  logic [CW-1:0] opa_q  [STAGES][STAGES];
  logic [CW-1:0] opb_q  [STAGES][STAGES];
  logic [CW-1:0] res_q  [STAGES][STAGES];

  // Next-state values for the stage registers.
  logic          valid_d [STAGES];
  logic [CW-1:0] opa_d   [STAGES][STAGES];
  logic [CW-1:0] opb_d   [STAGES][STAGES];
  logic [CW-1:0] res_d   [STAGES][STAGES];

  // Per-stage adder connections.
  logic [CW-1:0] ca     [STAGES];
  logic [CW-1:0] cb     [STAGES];
  logic [CW-1:0] cs     [STAGES];
  logic          cc_in  [STAGES];
  logic          cc_out [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // One global advance: the whole pipe moves unless a held result blocks it.
  assign advance     = !out_valid_94 || out_ready_94;
  assign in_ready_94 = advance;

  // Subtract is a + ~b + ~cin; fold the inversions in before chunking.
  assign b_eff   = b_94 ^ {WIDTH{sub_94}};
  assign cin_eff = cin_94 ^ sub_94;

`ifdef ADDPIPE_OVERFLOW_EN
  logic c_msb_last;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Adder inputs come straight from the ports at stage 0, else from the
    // previous stage's skewed operands and registered carry.
    if (k == 0) begin : g_first
      assign valid_d[k] = in_valid_94;
      assign ca[k]      = a_94[CW-1:0];
      assign cb[k]      = b_eff[CW-1:0];
      assign cc_in[k]   = cin_eff;
    end else begin : g_next
      assign valid_d[k] = ctrl_q[k-1].valid;
      assign ca[k]      = opa_q[k-1][k];
      assign cb[k]      = opb_q[k-1][k];
      assign cc_in[k]   = ctrl_q[k-1].carry;
    end

    if (k == STAGES - 1) begin : g_last_add
`ifdef ADDPIPE_OVERFLOW_EN
      addsub_chunk #(.CW(CW)) u_chunk (
        .a     (ca[k]),
        .b     (cb[k]),
        .cin   (cc_in[k]),
        .sum   (cs[k]),
        .cout  (cc_out[k]),
        .c_msb (c_msb_last)
      );
`else
      logic c_msb_unused;
      addsub_chunk #(.CW(CW)) u_chunk (
        .a     (ca[k]),
        .b     (cb[k]),
        .cin   (cc_in[k]),
        .sum   (cs[k]),
        .cout  (cc_out[k]),
        .c_msb (c_msb_unused)
      );
`endif
    end else begin : g_mid_add
      logic c_msb_unused;
      addsub_chunk #(.CW(CW)) u_chunk (
        .a     (ca[k]),
        .b     (cb[k]),
        .cin   (cc_in[k]),
        .sum   (cs[k]),
        .cout  (cc_out[k]),
        .c_msb (c_msb_unused)
      );
    end

    // Route every chunk slot: carry finished results forward, capture this
    // stage's result, keep pending operands moving until their stage.
    for (genvar j = 0; j < STAGES; j++) begin : g_slot
      if (j < k) begin : g_done
        assign res_d[k][j] = res_q[k-1][j];
        assign opa_d[k][j] = '0;
        assign opb_d[k][j] = '0;
      end else if (j == k) begin : g_calc
        assign res_d[k][j] = cs[k];
        assign opa_d[k][j] = '0;
        assign opb_d[k][j] = '0;
      end else begin : g_wait
        assign res_d[k][j] = '0;
        if (k == 0) begin : g_load
          assign opa_d[k][j] = a_94[j*CW +: CW];
          assign opb_d[k][j] = b_eff[j*CW +: CW];
        end else begin : g_skew
          assign opa_d[k][j] = opa_q[k-1][j];
          assign opb_d[k][j] = opb_q[k-1][j];
        end
      end
    end

    // Output assembly from the last stage's deskewed result chunks.
    assign sum_94[k*CW +: CW] = res_q[STAGES-1][k];
  end

  // Pipeline registers; all hold together while advance is low.
  always_ff @(posedge clk_94 or posedge reset_94) begin
    if (reset_94) begin
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        for (int j = 0; j < STAGES; j++) begin
          opa_q[k][j] <= '0;
          opb_q[k][j] <= '0;
          res_q[k][j] <= '0;
        end
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k].valid <= valid_d[k];
        ctrl_q[k].carry <= cc_out[k];
        for (int j = 0; j < STAGES; j++) begin
          opa_q[k][j] <= opa_d[k][j];
          opb_q[k][j] <= opb_d[k][j];
          res_q[k][j] <= res_d[k][j];
        end
      end
    end
  end

  assign out_valid_94 = ctrl_q[STAGES-1].valid;
  assign cout_94      = ctrl_q[STAGES-1].carry;

`ifdef ADDPIPE_OVERFLOW_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk_94 or posedge reset_94) begin
    if (reset_94) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= c_msb_last ^ cc_out[STAGES-1];
    end
  end

  assign ovf_94 = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (WIDTH=16, STAGES=4).
// Accepted beats are turned into expected results by an arithmetic model and
// queued; an independent monitor pops and compares every consumed result.
module tb_addsub_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDPIPE_OVERFLOW_EN
  logic         ovf;
`endif

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk_94       (clk),
    .reset_94     (rst),
    .in_valid_94  (in_valid),
    .in_ready_94  (in_ready),
    .a_94         (a),
    .b_94         (b),
    .sub_94       (sub),
    .cin_94       (cin),
    .out_valid_94 (out_valid),
    .out_ready_94 (out_ready),
    .sum_94       (sum),
    .cout_94      (cout)
`ifdef ADDPIPE_OVERFLOW_EN
    ,
    .ovf_94       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  exp_t         trk_e;
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_out = 0;
  bit           lat_mode = 0;
  bit           holding = 0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to the port view.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    exp_t r;
    int ux, uy, sx, sy, ci, full, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (s) begin
      full   = ux - uy - ci;
      sres   = sx - sy - ci;
      r.cout = (full >= 0);
    end else begin
      full   = ux + uy + ci;
      sres   = sx + sy + ci;
      r.cout = (full >= (1 << W));
    end
    r.sum = W'(full);
    r.ovf = (sres > 32767) || (sres < -32768);
    r.acc = 0;
    r.lat = 0;
    return r;
  endfunction

  // Stimulus tracker: record every accepted beat's expected response.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      trk_e     = model(a, b, sub, cin);
      trk_e.acc = cyc;
      trk_e.lat = lat_mode;
      sb.push_back(trk_e);
      n_acc++;
    end
  end

  // Monitor: stall behaviour and result comparison.
  always @(negedge clk) begin
    if (rst) begin
      holding = 0;
    end else begin
      if (holding) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'(held_sum));
        chk("hold_cout", 32'(cout), 32'(held_cout));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        holding   = 1;
        held_sum  = sum;
        held_cout = cout;
      end else begin
        holding = 0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum 0x%0h expected no result", sum);
        end else begin
          mon_e = sb.pop_front();
          chk("sum", 32'(sum), 32'(mon_e.sum));
          chk("cout", 32'(cout), 32'(mon_e.cout));
`ifdef ADDPIPE_OVERFLOW_EN
          chk("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
          if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(S));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic c);
    a        = x;
    b        = y;
    sub      = s;
    cin      = c;
    in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
  endtask

  task automatic drain(input int max_cycles);
    for (int t = 0; t < max_cycles; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int target;
    int guard;
    rst       = 1;
    in_valid  = 0;
    a         = '0;
    b         = '0;
    sub       = 0;
    cin       = 0;
    out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
`ifdef ADDPIPE_OVERFLOW_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed corner cases, back-to-back with latency checking.
    lat_mode = 1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    drain(50);
    lat_mode = 0;

    // Reset with three beats in flight: nothing may surface afterwards.
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0);
    send(16'h1234, 16'h0101, 1'b1, 1'b0);
    rst = 1;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_sum", 32'(sum), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    n0 = n_out;
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_beats", 32'(n_out - n0), 32'd0);

    // Back-pressure: 8 beats with the consumer stalled on cycles 5..9.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 256), 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = !(c >= 5 && c <= 9);
          @(posedge clk);
          #1;
        end
        out_ready = 1;
      end
    join
    drain(50);
    chk("bp_count", 32'(n_out - n0), 32'd8);

    // Random traffic with random valid/ready.
    target = n_acc + 10000;
    guard  = 0;
    while (n_acc < target && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid  = 0;
    out_ready = 1;
    chk("random_beats_issued", 32'(n_acc >= target), 32'd1);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
